mc_ctrl: RTL

- Multicycle main controller that sits directly upstream of the fetch stage.
- Sequences each instruction through IF/ID/EX/MEM/WB-style states and drives the fetch stage's PCWr, Br and J strobes.
- Also drives datapath enables (IR, register file, data memory, ALU control).
- Latches the instruction fields it decodes, because fetch's instr output changes once the PC advances at the end of IF.

---
 rtl/mc_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle main controller: steps each instruction through IF/ID/EX/MEM/WB/LWB/BR and drives fetch + datapath strobes.
// Latency: 2 cycles for j/jal/illegal, 3 for beq, 4 for ALU ops, 4+ for sw and 5+ for lw (MEM holds until dm_ack).
// Backpressure: the only stall source is dm_ack in MEM; MemRd/MemWr are held every cycle until it is seen.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset (forces every output to 0)
//   instr             instruction word from fetch; opcode/funct are captured at the end of IF
//   zero              ALU zero flag, used only in BR
//   dm_ack            data-memory done, used only in MEM
//   PCWr, Br, J       fetch strobes (PC write, branch-target select, jump-target select)
//   IRWr, RegWr       instruction-register load, register-file write
//   RegDst            0=rt, 1=rd, 2=$31
//   MemToReg          0=ALU, 1=memory, 2=pc_add4
//   MemRd, MemWr      data-memory read/write
//   ALUSrc, ExtOp     ALU B-operand select (1=immediate), immediate extension (1=sign)
//   alu_op            0=add, 1=sub, 2=or, 3=slt, 4=lui
//   illegal           one-cycle pulse in ID for an undecodable instruction
//   instr_cnt         retired-instruction counter (wraps)
//
// Build option: define MC_CTRL_JAL_EN to make op 0x03 (jal) legal; otherwise it decodes as illegal.

module mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               zero,
    input  logic               dm_ack,
    output logic               PCWr,
    output logic               Br,
    output logic               J,
    output logic               IRWr,
    output logic               RegWr,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               MemRd,
    output logic               MemWr,
    output logic               ALUSrc,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic [CNT_W-1:0]   instr_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_LWB = 3'd5,
        S_BR  = 3'd6,
        S_BAD = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(4);

    state_t     state, next_state;
    logic [5:0] op_q, funct_q;
    logic       retire;

    // Only opcode and funct steer control; the rest of the word belongs to the datapath.
    logic       unused_instr_bits;
    assign unused_instr_bits = ^instr[25:6];

    // Decode of the latched fields (fetch's instr has already moved on after IF).
    logic is_rtype, r_legal, is_mem, is_imm, alu_mem_legal;
    always_comb begin
        is_rtype      = (op_q == OP_RTYPE);
        r_legal       = (funct_q == FN_ADDU) || (funct_q == FN_SUBU) || (funct_q == FN_SLT);
        is_mem        = (op_q == OP_LW) || (op_q == OP_SW);
        is_imm        = (op_q == OP_ADDIU) || (op_q == OP_ORI) || (op_q == OP_LUI);
        alu_mem_legal = (is_rtype && r_legal) || is_imm || is_mem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IF;
            op_q    <= 6'h00;
            funct_q <= 6'h00;
        end else begin
            state <= next_state;
            if (state == S_IF) begin
                op_q    <= instr[31:26];
                funct_q <= instr[5:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
        end else if (retire) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        PCWr       = 1'b0;
        Br         = 1'b0;
        J          = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        RegDst     = 2'd0;
        MemToReg   = 2'd0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;

        case (state)
            S_IF: begin
                IRWr       = 1'b1;
                PCWr       = 1'b1;
                next_state = S_ID;
            end

            S_ID: begin
                if (op_q == OP_J) begin
                    PCWr       = 1'b1;
                    J          = 1'b1;
                    retire     = 1'b1;
                    next_state = S_IF;
                end
`ifdef MC_CTRL_JAL_EN
                else if (op_q == OP_JAL) begin
                    // pc_add4 already holds the return address because PC advanced in IF.
                    PCWr       = 1'b1;
                    J          = 1'b1;
                    RegWr      = 1'b1;
                    RegDst     = 2'd2;
                    MemToReg   = 2'd2;
                    retire     = 1'b1;
                    next_state = S_IF;
                end
`endif
                else if (op_q == OP_BEQ) begin
                    next_state = S_BR;
                end else if (alu_mem_legal) begin
                    next_state = S_EX;
                end else begin
                    illegal    = 1'b1;
                    next_state = S_IF;
                end
            end

            S_EX: begin
                ALUSrc = !is_rtype;
                ExtOp  = (op_q != OP_ORI);
                if (is_rtype) begin
                    case (funct_q)
                        FN_SUBU: alu_op = ALU_SUB;
                        FN_SLT:  alu_op = ALU_SLT;
                        default: alu_op = ALU_ADD;
                    endcase
                end else begin
                    case (op_q)
                        OP_ORI:  alu_op = ALU_OR;
                        OP_LUI:  alu_op = ALU_LUI;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                next_state = is_mem ? S_MEM : S_WB;
            end

            S_MEM: begin
                MemRd = (op_q == OP_LW);
                MemWr = (op_q == OP_SW);
                if (dm_ack) begin
                    if (op_q == OP_LW) begin
                        next_state = S_LWB;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_IF;
                    end
                end
            end

            S_WB: begin
                RegWr      = 1'b1;
                RegDst     = is_rtype ? 2'd1 : 2'd0;
                MemToReg   = 2'd0;
                retire     = 1'b1;
                next_state = S_IF;
            end

            S_LWB: begin
                RegWr      = 1'b1;
                RegDst     = 2'd0;
                MemToReg   = 2'd1;
                retire     = 1'b1;
                next_state = S_IF;
            end

            S_BR: begin
                // PC already points past the branch, so fetch's pc+imm is the real target.
                alu_op     = ALU_SUB;
                ALUSrc     = 1'b0;
                PCWr       = zero;
                Br         = zero;
                retire     = 1'b1;
                next_state = S_IF;
            end

            default: begin
                next_state = S_IF;
            end
        endcase

        // Reset gates the outputs combinationally so a write strobe cannot outlive rst rising.
        if (rst) begin
            next_state = S_IF;
            retire     = 1'b0;
            PCWr       = 1'b0;
            Br         = 1'b0;
            J          = 1'b0;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            RegDst     = 2'd0;
            MemToReg   = 2'd0;
            MemRd      = 1'b0;
            MemWr      = 1'b0;
            ALUSrc     = 1'b0;
            ExtOp      = 1'b0;
            alu_op     = ALU_ADD;
            illegal    = 1'b0;
        end
    end

endmodule
